// File: rtl/pong_vga_timing_if.sv
// pong_vga_timing_if
// Raster timing bundle from the VGA timing generator to the pong render logic.
//   pix_stb     : pixel-advance strobe
//   hpos, vpos  : current column / line (10 bits each)
//   hsync/vsync : sync pulses, polarity set by the generator
//   display_on  : (hpos,vpos) lies in the visible area
//   line_end    : one-cycle pulse on the last pixel of a line
//   frame_end   : one-cycle pulse on the last pixel of a frame
//   frame_count : completed-frame counter, wraps at 256
// Modports: master = timing generator, slave = consumer.
interface pong_vga_timing_if;
  logic       pix_stb;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_end;
  logic       frame_end;
  logic [7:0] frame_count;

  modport master (
    output pix_stb, hpos, vpos, hsync, vsync, display_on,
           line_end, frame_end, frame_count
  );

  modport slave (
    input  pix_stb, hpos, vpos, hsync, vsync, display_on,
           line_end, frame_end, frame_count
  );
endinterface

// File: rtl/pong_vga_timing.sv
// pong_vga_timing
// VGA raster timing generator for the pong core: position counters, sync
// pulses, display-active flag, line/frame strobes and a frame counter.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   ena   : enable; low freezes all timing state and silences the strobes
//   vga   : pong_vga_timing_if.master, all timing outputs
// H_TOTAL and V_TOTAL must fit in 10 bits; CLK_DIV must be >= 1.
module pong_vga_timing #(
  parameter int H_DISPLAY        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_DISPLAY        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int CLK_DIV          = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  pong_vga_timing_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic          SYNC_ACT   = (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  logic [PW-1:0] presc_reg, presc_next;
  logic [9:0]    hpos_reg, hpos_next;
  logic [9:0]    vpos_reg, vpos_next;
  logic [7:0]    frame_count_reg, frame_count_next;
  logic          pix_stb_reg, pix_stb_next;
  logic          line_end_reg, line_end_next;
  logic          frame_end_reg, frame_end_next;
  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;
  logic          display_on_reg, display_on_next;
  logic          hs_window, vs_window;

  // Next-state counters. With ena low everything holds and no strobe is made.
  always_comb begin
    presc_next       = presc_reg;
    pix_stb_next     = 1'b0;
    hpos_next        = hpos_reg;
    vpos_next        = vpos_reg;
    frame_count_next = frame_count_reg;
    if (ena) begin
      pix_stb_next = (presc_reg == PRESC_LAST);
      presc_next   = pix_stb_next ? '0 : presc_reg + PW'(1);
      if (pix_stb_next) begin
        if (hpos_reg == H_LAST) begin
          hpos_next = '0;
          if (vpos_reg == V_LAST) begin
            vpos_next = '0;
            // Frame counted as the raster returns to (0,0).
            frame_count_next = frame_count_reg + 8'd1;
          end else begin
            vpos_next = vpos_reg + 10'd1;
          end
        end else begin
          hpos_next = hpos_reg + 10'd1;
        end
      end
    end
  end

  // Decode from the next-state position so the registered sync/blank flags
  // line up with the registered position in the same cycle.
  always_comb begin
    hs_window       = (hpos_next >= HS_START) && (hpos_next < HS_END);
    vs_window       = (vpos_next >= VS_START) && (vpos_next < VS_END);
    hsync_next      = hs_window ? SYNC_ACT : ~SYNC_ACT;
    vsync_next      = vs_window ? SYNC_ACT : ~SYNC_ACT;
    display_on_next = (hpos_next < H_VIS) && (vpos_next < V_VIS);
    line_end_next   = pix_stb_next && (hpos_next == H_LAST);
    frame_end_next  = line_end_next && (vpos_next == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg       <= '0;
      hpos_reg        <= '0;
      vpos_reg        <= '0;
      frame_count_reg <= '0;
      pix_stb_reg     <= 1'b0;
      line_end_reg    <= 1'b0;
      frame_end_reg   <= 1'b0;
      hsync_reg       <= ~SYNC_ACT;
      vsync_reg       <= ~SYNC_ACT;
      display_on_reg  <= 1'b1;
    end else begin
      presc_reg       <= presc_next;
      hpos_reg        <= hpos_next;
      vpos_reg        <= vpos_next;
      frame_count_reg <= frame_count_next;
      pix_stb_reg     <= pix_stb_next;
      line_end_reg    <= line_end_next;
      frame_end_reg   <= frame_end_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      display_on_reg  <= display_on_next;
    end
  end

  // Strobes are also masked by ena so they drop in the same cycle ena falls,
  // not one edge later; consumers never see a strobe for a frozen position.
  assign vga.pix_stb     = pix_stb_reg & ena;
  assign vga.line_end    = line_end_reg & ena;
  assign vga.frame_end   = frame_end_reg & ena;
  assign vga.hpos        = hpos_reg;
  assign vga.vpos        = vpos_reg;
  assign vga.hsync       = hsync_reg;
  assign vga.vsync       = vsync_reg;
  assign vga.display_on  = display_on_reg;
  assign vga.frame_count = frame_count_reg;

endmodule

// File: tb/tb_pong_vga_timing.sv
// Testbench for pong_vga_timing: three instances (default 640x480, default
// geometry with two clocks per pixel, and a tiny 16x8 raster with active-high
// sync for whole-frame and counter-wrap tests).
module tb_pong_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ena;

  pong_vga_timing_if if_a ();
  pong_vga_timing_if if_b ();
  pong_vga_timing_if if_c ();

  pong_vga_timing dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vga(if_a)
  );

  pong_vga_timing #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vga(if_b)
  );

  pong_vga_timing #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1), .CLK_DIV(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vga(if_c)
  );

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb, pol, div;
  } cfg_t;

  typedef struct {
    int presc, h, v, fc;
    bit stb;
  } mstate_t;

  typedef struct {
    int         cyc;
    logic [9:0] h, v;
    logic       hs, de, le;
  } vec_t;

  cfg_t    cfg;
  int      sel;
  mstate_t m;
  mstate_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  vec_t    tbl[10];

  // Outputs of the instance under test.
  logic [9:0] o_hpos, o_vpos;
  logic [7:0] o_fc;
  logic       o_stb, o_le, o_fe, o_hs, o_vs, o_de;

  always_comb begin
    o_hpos = if_a.hpos; o_vpos = if_a.vpos; o_fc = if_a.frame_count;
    o_stb  = if_a.pix_stb; o_le = if_a.line_end; o_fe = if_a.frame_end;
    o_hs   = if_a.hsync; o_vs = if_a.vsync; o_de = if_a.display_on;
    if (sel == 1) begin
      o_hpos = if_b.hpos; o_vpos = if_b.vpos; o_fc = if_b.frame_count;
      o_stb  = if_b.pix_stb; o_le = if_b.line_end; o_fe = if_b.frame_end;
      o_hs   = if_b.hsync; o_vs = if_b.vsync; o_de = if_b.display_on;
    end else if (sel == 2) begin
      o_hpos = if_c.hpos; o_vpos = if_c.vpos; o_fc = if_c.frame_count;
      o_stb  = if_c.pix_stb; o_le = if_c.line_end; o_fe = if_c.frame_end;
      o_hs   = if_c.hsync; o_vs = if_c.vsync; o_de = if_c.display_on;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference raster: advance one clock given the sampled inputs.
  function automatic mstate_t step(input mstate_t s, input cfg_t c, input logic r, input logic e);
    mstate_t n;
    int htot, vtot;
    htot = c.hd + c.hf + c.hs + c.hb;
    vtot = c.vd + c.vf + c.vs + c.vb;
    n = s;
    if (!r) begin
      n = '{default: 0};
    end else if (!e) begin
      n.stb = 1'b0;
    end else begin
      n.stb   = (s.presc == c.div - 1);
      n.presc = n.stb ? 0 : s.presc + 1;
      if (n.stb) begin
        n.h = s.h + 1;
        if (n.h == htot) begin
          n.h = 0;
          n.v = s.v + 1;
          if (n.v == vtot) begin
            n.v  = 0;
            n.fc = (s.fc + 1) % 256;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] expect_vec(input mstate_t s, input cfg_t c, input logic e);
    int  htot, vtot;
    bit  hs_in, vs_in, hs, vs, de, stb, le, fe;
    htot  = c.hd + c.hf + c.hs + c.hb;
    vtot  = c.vd + c.vf + c.vs + c.vb;
    hs_in = (s.h >= c.hd + c.hf) && (s.h < c.hd + c.hf + c.hs);
    vs_in = (s.v >= c.vd + c.vf) && (s.v < c.vd + c.vf + c.vs);
    hs    = (c.pol != 0) ? hs_in : !hs_in;
    vs    = (c.pol != 0) ? vs_in : !vs_in;
    de    = (s.h < c.hd) && (s.v < c.vd);
    stb   = s.stb && e;
    le    = stb && (s.h == htot - 1);
    fe    = le && (s.v == vtot - 1);
    return 64'({10'(s.h), 10'(s.v), 8'(s.fc), stb, le, fe, hs, vs, de});
  endfunction

  function automatic logic [63:0] act_vec();
    return 64'({o_hpos, o_vpos, o_fc, o_stb, o_le, o_fe, o_hs, o_vs, o_de});
  endfunction

  // One clock: the model consumes the same inputs the DUT sees at the edge,
  // queues its expectation, and it is checked on the following falling edge.
  task automatic tick();
    mstate_t s;
    @(posedge clk);
    m = step(m, cfg, rst_n, ena);
    exp_q.push_back(m);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("model", act_vec(), expect_vec(s, cfg, ena));
    end
  endtask

  task automatic wait_pos(input int h, input int v, input int budget, input string name);
    int n = 0;
    while (!(o_hpos == 10'(h) && o_vpos == 10'(v)) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'({o_hpos, o_vpos}), 64'({10'(h), 10'(v)}));
  endtask

  task automatic wait_fe(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!o_fe && n < budget);
    check(name, 64'(o_fe), 64'd1);
  endtask

  task automatic switch_to(input int s, input cfg_t c);
    rst_n = 1'b0;
    tick();
    sel = s;
    cfg = c;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_low, de_cnt, le_cnt, n, stb_cnt, vs_cnt, fe_cnt, idx;

    tbl[0] = '{0,   10'd1,   10'd0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{638, 10'd639, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{639, 10'd640, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{654, 10'd655, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{655, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{750, 10'd751, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{751, 10'd752, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{797, 10'd798, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{798, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{799, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0};

    m     = '{default: 0};
    sel   = 0;
    cfg   = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1};
    rst_n = 1'b0;
    ena   = 1'b1;

    // Reset held for 3 cycles with ena high.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_state",
            64'({o_hpos, o_vpos, o_fc, o_stb, o_le, o_fe, o_hs, o_vs, o_de}),
            64'({10'd0, 10'd0, 8'd0, 6'b000111}));
    end
    rst_n = 1'b1;

    // One full line at default timing, table checkpoints plus totals.
    hs_low = 0; de_cnt = 0; le_cnt = 0; idx = 0;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (!o_hs) hs_low++;
      if (o_de) de_cnt++;
      if (o_le) le_cnt++;
      if (idx < 10 && tbl[idx].cyc == k) begin
        check($sformatf("line_vec%0d", idx),
              64'({o_hpos, o_vpos, o_hs, o_de, o_le}),
              64'({tbl[idx].h, tbl[idx].v, tbl[idx].hs, tbl[idx].de, tbl[idx].le}));
        idx++;
      end
    end
    check("hsync_low_cycles", 64'(hs_low), 64'd96);
    check("display_on_cycles", 64'(de_cnt), 64'd640);
    check("line_end_pulses", 64'(le_cnt), 64'd1);

    // ena gating at hpos=700 (inside hsync).
    wait_pos(700, 1, 1000, "reach_hpos700");
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("ena_hold", 64'({o_hpos, o_hs, o_stb, o_le, o_fe}), 64'({10'd700, 4'b0000}));
    end
    ena = 1'b1;
    tick();
    check("ena_resume", 64'({o_hpos, o_stb}), 64'({10'd701, 1'b1}));

    // Two clocks per pixel.
    switch_to(1, '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2});
    tick();
    check("div2_first", 64'({o_hpos, o_stb}), 64'({10'd0, 1'b0}));
    tick();
    check("div2_second", 64'({o_hpos, o_stb}), 64'({10'd1, 1'b1}));
    n = 0;
    do begin tick(); n++; end while (!o_le && n < 4000);
    check("div2_first_line_end", 64'(o_le), 64'd1);
    n = 0; stb_cnt = 0;
    do begin
      tick();
      n++;
      if (o_stb) stb_cnt++;
      if (n == 1) check("div2_le_width", 64'({o_le, o_hpos}), 64'({1'b0, 10'd799}));
    end while (!o_le && n < 4000);
    check("div2_line_period", 64'(n), 64'd1600);
    check("div2_stb_count", 64'(stb_cnt), 64'd800);

    // Tiny raster: 16x8, active-high sync.
    switch_to(2, '{8, 2, 3, 3, 4, 1, 2, 1, 1, 1});
    n = 0; vs_cnt = 0; fe_cnt = 0;
    do begin
      tick();
      n++;
      if (o_vs) vs_cnt++;
      if (o_fe) fe_cnt++;
    end while (!o_fe && n < 400);
    check("frame_end_pos", 64'({o_hpos, o_vpos, o_le}), 64'({10'd15, 10'd7, 1'b1}));
    check("vsync_cycles", 64'(vs_cnt), 64'd32);
    check("frame_end_pulses", 64'(fe_cnt), 64'd1);
    tick();
    check("frame_count_1", 64'({o_fc, o_hpos, o_vpos, o_fe}), 64'({8'd1, 10'd0, 10'd0, 1'b0}));
    for (int f = 2; f <= 257; f++) begin
      wait_fe(200, "frame_end_seen");
      tick();
      if (f == 2)   check("frame_count_2", 64'(o_fc), 64'd2);
      if (f == 255) check("frame_count_255", 64'(o_fc), 64'd255);
      if (f == 256) check("frame_count_wrap", 64'(o_fc), 64'd0);
    end
    check("frame_count_after_wrap", 64'(o_fc), 64'd1);

    // Reset on the edge that would reach the last pixel of the frame.
    wait_pos(14, 7, 200, "reach_last_minus1");
    rst_n = 1'b0;
    tick();
    check("reset_race",
          64'({o_hpos, o_vpos, o_fc, o_stb, o_le, o_fe, o_de}),
          64'({10'd0, 10'd0, 8'd0, 4'b0001}));
    rst_n = 1'b1;
    tick();
    check("after_race_release", 64'({o_hpos, o_vpos, o_fc}), 64'({10'd1, 10'd0, 8'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
